spectrum_bar_scaler: RTL and testbench
======================================

Name: spectrum_bar_scaler

Overview:
- Sits between FFT_Processor and video_sync_generator. Converts the 16 frequency-bin magnitudes into 6-bit bar heights with peak-hold/decay smoothing.
- Processes one bin per cycle from a snapshot taken when the FFT's done rises. Publishes all 16 heights atomically, with a one-cycle ready strobe, for the display side.

Parameters:
SHIFT, 12, right-shift applied to each 24-bit magnitude before clamping
MAX_H, 47, maximum bar height (must be ≤63)
DECAY, 1, height units subtracted from a held bar per frame

Ports:
clk  input  1  system clock (same domain as FFT_Processor)
reset  input  1  asynchronous, active-low reset
done  input  1  FFT frame complete (level; rising edge triggers)
f0..f15  input  24 each  unsigned bin magnitudes, valid while done high
h0..h15  output  6 each  published bar heights
ready  output  1  one-cycle pulse when h0..h15 update
busy  output  1  high while state != IDLE

Behaviour:
- Reset (reset=0, async):
  - h0..h15=0, working bars=0, snapshot=0.
  - ready=0, busy=0, state=IDLE, idx=0, pending=0, done_q=0.
- Trigger: trig = done & ~done_q, evaluated at each edge; done_q <= done every edge.
  - done held high gives exactly one trigger.
  - done high when leaving reset triggers once.
- States:
  - IDLE:
    - On trig: snapshot f0..f15 into 16x24 shadow regs, idx<=0, go to SCAN.
  - SCAN:
    - Each edge processes bin idx and writes work[idx]; idx increments.
    - At idx=15, go to PUBLISH.
    - Exactly 16 SCAN edges.
  - PUBLISH (1 cycle):
    - Copy work[0..15] to h0..h15 and assert ready for this one cycle.
    - If pending or trig at this edge: clear pending, re-snapshot current f0..f15, idx<=0, go to SCAN.
    - Otherwise go to IDLE.
- Per-bin arithmetic, all unsigned:
  - s = snap[idx] >> SHIFT.
  - c = (s > MAX_H) ? MAX_H : s[5:0].
  - d = (work[idx] > DECAY) ? work[idx]-DECAY : 0.
  - work[idx] <= max(c, d).
  - No wrap: d never underflows, c never exceeds MAX_H.
- Latency: trig at edge E0 → ready high in the cycle following edge E17, i.e. 17 cycles after the trigger edge. h0..h15 change only at the PUBLISH edge, so the display never sees a partially updated frame.
- trig during SCAN:
  - Sets pending (one-deep).
  - Further triggers while pending=1 are dropped.
  - Pending frame samples f at the PUBLISH edge, not at the trigger.
- Back-to-back frames: ready pulses are 17 cycles apart minimum.
- ready is never high for two consecutive cycles.
- Reset asserted mid-SCAN/PUBLISH:
  - Immediate return to reset values.
  - No ready pulse is produced for the aborted frame.

Test Plan:
- Reset with all f=0xFFFFFF, done=0 → h0..h15=0, ready=0, busy=0; release reset, 30 idle cycles → no ready, h unchanged.
- f3=0x00A000, others 0, done 0→1 at edge E0 → busy from E0, ready high one cycle after E17, h3=10, all other h=0, busy=0 the cycle after.
- f0=0xFFFFFF, f1=0x02F000 (47 after shift), f2=0x030000 (48) → h0=47, h1=47, h2=47 (clamped).
- After h3=10, four successive all-zero frames → h3 sequence 9,8,7,6; zero bins stay 0; with DECAY=1, a bin at 1 goes to 0, never wraps to 63.
- Peak hold: h5=20, next frame f5 gives 15 → h5=19 (decay wins); next gives 25 → h5=25.
- Second done rising edge 5 cycles into SCAN → second ready exactly 17 cycles after first; third rising edge also during that first SCAN → dropped; done held high 40 cycles → single ready.
- Assert reset at SCAN idx=8 → h0..h15, ready, busy go 0 without waiting for clk; after release, no ready until the next done rising edge.

Source files
------------

// File: rtl/spectrum_bar_scaler_if.sv
// Spectrum bar scaler bus: bin magnitudes in, published bar heights out.
//   done  : FFT frame complete (level; a rising edge starts a frame)
//   f     : 16 x 24-bit unsigned bin magnitudes, valid while done is high
//   h     : 16 x 6-bit published bar heights
//   ready : one-cycle pulse when h updates
//   busy  : high while the scaler is not idle
// master = FFT/display side, slave = scaler.
interface spectrum_bar_scaler_if;
  logic                done;
  logic [15:0][23:0]   f;
  logic [15:0][5:0]    h;
  logic                ready;
  logic                busy;

  modport master (
    output done, f,
    input  h, ready, busy
  );

  modport slave (
    input  done, f,
    output h, ready, busy
  );
endinterface

// File: rtl/spectrum_bar_scaler.sv
// spectrum_bar_scaler
// Turns 16 FFT bin magnitudes into 6-bit bar heights with peak-hold/decay.
// A rising edge on done snapshots all bins; the bins are then processed one
// per cycle (16 cycles) and all heights are published together with a
// one-cycle ready pulse, so the display never sees a half-updated frame.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : spectrum_bar_scaler_if.slave (done, f in; h, ready, busy out)
module spectrum_bar_scaler #(
  parameter int unsigned SHIFT = 12,
  parameter int unsigned MAX_H = 47,
  parameter int unsigned DECAY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  spectrum_bar_scaler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PUBLISH
  } state_t;

  state_t             state;
  logic [15:0][23:0]  snap;
  logic [15:0][5:0]   work;
  logic [15:0][5:0]   h_q;
  logic [3:0]         idx;
  logic               pending;
  logic               done_q;
  logic               ready_q;
  logic               busy_q;
  logic               trig;

  logic [23:0]        s;
  logic [5:0]         c;
  logic [5:0]         d;
  logic [5:0]         nxt;

  assign trig      = bus.done & ~done_q;
  assign bus.h     = h_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;

  // Per-bin height: clamp the scaled magnitude, decay the held bar without
  // underflow, keep whichever is larger.
  always_comb begin
    s   = snap[idx] >> SHIFT;
    c   = (s > 24'(MAX_H)) ? 6'(MAX_H) : s[5:0];
    d   = (work[idx] > 6'(DECAY)) ? (work[idx] - 6'(DECAY)) : '0;
    nxt = (c > d) ? c : d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      snap    <= '0;
      work    <= '0;
      h_q     <= '0;
      idx     <= '0;
      pending <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q  <= bus.done;
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            snap   <= bus.f;
            idx    <= '0;
            state  <= SCAN;
            busy_q <= 1'b1;
          end
        end
        SCAN: begin
          work[idx] <= nxt;
          idx       <= idx + 4'd1;
          // One-deep queue: a trigger seen while one is already pending is lost.
          if (trig) pending <= 1'b1;
          if (idx == 4'd15) state <= PUBLISH;
        end
        PUBLISH: begin
          h_q     <= work;
          ready_q <= 1'b1;
          // A queued frame takes the magnitudes present now, not those
          // present when its trigger arrived.
          if (pending || trig) begin
            pending <= 1'b0;
            snap    <= bus.f;
            idx     <= '0;
            state   <= SCAN;
          end else begin
            state   <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_bar_scaler.sv
// Directed self-checking bench for spectrum_bar_scaler.
module tb_spectrum_bar_scaler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spectrum_bar_scaler_if bus ();

  spectrum_bar_scaler #(
    .SHIFT(12),
    .MAX_H(47),
    .DECAY(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   ready_cnt = 0;
  int   double_ready = 0;
  logic ready_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.ready === 1'b1) ready_cnt++;
    if (bus.ready === 1'b1 && ready_prev === 1'b1) double_ready++;
    ready_prev = bus.ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_h(input string tag, input logic [15:0][5:0] exp);
    checks++;
    assert (bus.h === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, bus.h, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise done for one edge, then expect ready exactly 17 cycles later.
  task automatic frame(input string tag);
    int lat;
    bus.done = 1'b1;
    step();
    check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    bus.done = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd17);
    step();
    check({tag, "_ready_drop"}, 32'(bus.ready), 32'd0);
    check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [15:0][5:0] exp_h;
    int base;
    int n;
    int r1;
    int r2;

    // Reset with all magnitudes saturated.
    reset    = 1'b0;
    bus.done = 1'b0;
    for (int i = 0; i < 16; i++) bus.f[i] = 24'hFFFFFF;
    #22;
    check_h("reset_h", '0);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    step();
    reset = 1'b1;
    repeat (30) step();
    check("idle_no_ready", 32'(ready_cnt), 32'd0);
    check_h("idle_h", '0);

    // Single bin.
    bus.f    = '0;
    bus.f[3] = 24'h00A000;
    frame("f1");
    exp_h    = '0;
    exp_h[3] = 6'd10;
    check_h("f1_h", exp_h);

    // Decay over empty frames.
    for (int j = 0; j < 4; j++) begin
      bus.f = '0;
      frame("decay");
      check("decay_h3", 32'(bus.h[3]), 32'(9 - j));
      check("decay_h0", 32'(bus.h[0]), 32'd0);
    end

    // Clamping.
    bus.f    = '0;
    bus.f[0] = 24'hFFFFFF;
    bus.f[1] = 24'h02F000;
    bus.f[2] = 24'h030000;
    frame("clamp");
    check("clamp_h0", 32'(bus.h[0]), 32'd47);
    check("clamp_h1", 32'(bus.h[1]), 32'd47);
    check("clamp_h2", 32'(bus.h[2]), 32'd47);
    check("clamp_h3", 32'(bus.h[3]), 32'd5);

    // Bar at 1 decays to 0 and stays there.
    bus.f    = '0;
    bus.f[4] = 24'h001000;
    frame("one");
    check("one_h4", 32'(bus.h[4]), 32'd1);
    check("one_h0", 32'(bus.h[0]), 32'd46);
    bus.f = '0;
    frame("zero_a");
    check("zero_a_h4", 32'(bus.h[4]), 32'd0);
    frame("zero_b");
    check("zero_b_h4", 32'(bus.h[4]), 32'd0);
    check("zero_b_h3", 32'(bus.h[3]), 32'd2);

    // Peak hold.
    bus.f[5] = 24'h014000;
    frame("pk20");
    check("pk20_h5", 32'(bus.h[5]), 32'd20);
    bus.f[5] = 24'h00F000;
    frame("pk15");
    check("pk15_h5", 32'(bus.h[5]), 32'd19);
    check("pk15_h3", 32'(bus.h[3]), 32'd0);
    bus.f[5] = 24'h019000;
    frame("pk25");
    check("pk25_h5", 32'(bus.h[5]), 32'd25);
    check("pk25_h0", 32'(bus.h[0]), 32'd41);

    // Back-to-back: retrigger during SCAN, a further retrigger is dropped,
    // and the queued frame samples f at the publish edge.
    bus.f    = '0;
    bus.done = 1'b1;
    step();                 // E0
    bus.done = 1'b0;
    repeat (3) step();      // E1..E3
    bus.done = 1'b1;
    step();                 // E4: queued
    bus.done = 1'b0;
    step();                 // E5
    bus.done = 1'b1;
    step();                 // E6: dropped
    bus.done = 1'b0;
    bus.f[5] = 24'h03F000;
    n  = 0;
    r1 = -1;
    r2 = -1;
    for (int k = 7; k <= 70; k++) begin
      step();
      if (bus.ready === 1'b1) begin
        n++;
        if (n == 1) begin
          r1 = k;
          check("b2b_first_h5", 32'(bus.h[5]), 32'd24);
        end else if (n == 2) begin
          r2 = k;
          check("b2b_second_h5", 32'(bus.h[5]), 32'd47);
        end
      end
    end
    check("b2b_first_lat", 32'(r1), 32'd17);
    check("b2b_spacing", 32'(r2 - r1), 32'd17);
    check("b2b_count", 32'(n), 32'd2);

    // done held high gives one frame.
    base     = ready_cnt;
    bus.done = 1'b1;
    repeat (40) step();
    bus.done = 1'b0;
    repeat (20) step();
    check("held_count", 32'(ready_cnt - base), 32'd1);

    // Reset in the middle of SCAN.
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    repeat (8) step();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check_h("abort_h", '0);
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    #20;
    reset = 1'b1;
    base  = ready_cnt;
    repeat (30) step();
    check("abort_no_ready", 32'(ready_cnt - base), 32'd0);
    check("abort_idle_busy", 32'(bus.busy), 32'd0);

    // Fresh frame after the abort starts from cleared bars.
    bus.f    = '0;
    bus.f[3] = 24'h00A000;
    frame("post");
    exp_h    = '0;
    exp_h[3] = 6'd10;
    check_h("post_h", exp_h);

    check("no_double_ready", 32'(double_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
